// File: rtl/tv_pkg.sv
// Shared definitions for the golden-vector writer: FSM encoding and record layout.
package tv_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSettle = 2'd1,
    StOffer  = 2'd2,
    StDone   = 2'd3
  } tv_state_e;

  // A record is {dut_in, dut_out}: the sampled response sits in the LSBs.
  localparam int unsigned RecOutLsb = 0;

  function automatic int unsigned rec_in_lsb(input int unsigned nout);
    return RecOutLsb + nout;
  endfunction

endpackage

// File: rtl/tv_settle_timer.sv
// Loadable down-counter with a zero flag; paces the settle wait between stimulus and sampling.
module tv_settle_timer #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  output logic             zero_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/tv_generator.sv
// Golden-vector writer: sweeps all 2**NIN stimuli, waits SETTLE cycles, and offers
// {dut_in, dut_out} records at ascending addresses through a valid/ready port.
module tv_generator
  import tv_pkg::*;
#(
  parameter int unsigned NIN    = 3,
  parameter int unsigned NOUT   = 1,
  parameter int unsigned SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic [NIN-1:0]       dut_in,
  input  logic [NOUT-1:0]      dut_out,
  output logic                 wr_valid,
  input  logic                 wr_ready,
  output logic [NIN-1:0]       wr_addr,
  output logic [NIN+NOUT-1:0]  wr_data,
  output logic                 busy,
  output logic                 done,
  output logic [NIN:0]         vec_count
);

  localparam int unsigned TimerWidth = $clog2(SETTLE) + 1;
  localparam logic [TimerWidth-1:0] SettleLoad = TimerWidth'(SETTLE - 1);
  localparam logic [NIN-1:0] LastIdx = {NIN{1'b1}};
  localparam int unsigned InLsb = rec_in_lsb(NOUT);

  tv_state_e             state_q, state_d;
  logic [NIN-1:0]        idx_q, idx_d;
  logic                  valid_q, valid_d;
  logic [NIN-1:0]        addr_q, addr_d;
  logic [NIN+NOUT-1:0]   data_q, data_d;
  logic                  busy_q, busy_d;
  logic [NIN:0]          cnt_q, cnt_d;
  logic                  tmr_load, tmr_en, tmr_zero;

  tv_settle_timer #(
    .Width (TimerWidth)
  ) u_settle_timer (
    .clk_i      (clk),
    .reset_i    (reset),
    .load_i     (tmr_load),
    .load_val_i (SettleLoad),
    .en_i       (tmr_en),
    .zero_o     (tmr_zero)
  );

  // The timer runs SETTLE cycles from the edge that updates dut_in, so the sample is taken
  // on the SETTLE+1-th edge counting that update edge, and records pace at SETTLE+1 cycles.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    valid_d  = valid_q;
    addr_d   = addr_q;
    data_d   = data_q;
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StSettle;
          idx_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          tmr_load = 1'b1;
        end
      end
      StSettle: begin
        tmr_en = 1'b1;
        if (tmr_zero) begin
          data_d[RecOutLsb +: NOUT] = dut_out;
          data_d[InLsb +: NIN]      = idx_q;
          addr_d                    = idx_q;
          valid_d                   = 1'b1;
          state_d                   = StOffer;
        end
      end
      StOffer: begin
        if (wr_ready) begin
          cnt_d   = cnt_q + 1'b1;
          valid_d = 1'b0;
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d    = idx_q + 1'b1;
            tmr_load = 1'b1;
            state_d  = StSettle;
          end
        end
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dut_in    = idx_q;
  assign wr_valid  = valid_q;
  assign wr_addr   = addr_q;
  assign wr_data   = data_q;
  assign busy      = busy_q;
  assign done      = (state_q == StDone);
  assign vec_count = cnt_q;

endmodule
